byte_lane_memory_ctrl: RTL and testbench

//  Parametrised byte-lane data memory with valid/ready request and response channels.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/byte_lane_memory_ctrl_if.sv | 29 ++
 rtl/mem_byte_bank.sv | 21 ++
 rtl/byte_lane_memory_ctrl.sv | 154 +++++++++++++++
 tb/tb_byte_lane_memory_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-lane memory controller: FSM encodings,
// lane/row sizing helpers and the lane<->bank rotate index.
package mem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic int unsigned lanes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned lane_w_of(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned row_w_of(input int unsigned addr_w, input int unsigned data_w);
        return addr_w - lane_w_of(data_w);
    endfunction

    // Rotate an index by shift positions within a ring of lanes entries.
    function automatic int unsigned rot_idx(input int unsigned idx, input int unsigned shift,
                                            input int unsigned lanes);
        return (idx + shift) % lanes;
    endfunction

endpackage

// File: rtl/byte_lane_memory_ctrl_if.sv
// Request/response channel bundle for byte_lane_memory_ctrl.
interface byte_lane_memory_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LANES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_bank.sv
// One byte-wide bank: synchronous write, read data follows the row address.
module mem_byte_bank #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata_c
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/byte_lane_memory_ctrl.sv
// Byte-lane data memory with valid/ready request and response channels.
// Define BLMEM_MISALIGN_EN to split misaligned requests into two beats.
module byte_lane_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    byte_lane_memory_ctrl_if.slave bus
);

    localparam int unsigned LANES  = lanes_of(DATA_W);
    localparam int unsigned LANE_W = lane_w_of(DATA_W);
    localparam int unsigned ROW_W  = row_w_of(ADDR_W, DATA_W);
    localparam int unsigned DEPTH  = 2 ** ROW_W;

    logic [1:0]        state_q, state_d;
    logic              req_ready_q, rsp_valid_q, rsp_err_q, err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rdata_d;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LANES-1:0]  be_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept, aligned, beat0_en, beat1_en;
    logic [LANE_W-1:0] off;
    logic [ROW_W-1:0]  row_q;

    logic [LANE_W-1:0] bank_lane [LANES];
    logic [LANE_W-1:0] lane_bank [LANES];
    logic              bank_first [LANES];
    logic              bank_we [LANES];
    logic [ROW_W-1:0]  bank_addr [LANES];
    logic [7:0]        bank_wdata [LANES];
    logic [7:0]        bank_rdata [LANES];
    logic [7:0]        wbyte [LANES];

    assign accept  = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
    assign off     = addr_q[LANE_W-1:0];
    assign row_q   = addr_q[ADDR_W-1:LANE_W];
    assign aligned = (off == '0);

`ifdef BLMEM_MISALIGN_EN
    logic [ROW_W-1:0] row_nxt;
    assign row_nxt  = row_q + ROW_W'(1);
    assign beat0_en = (state_q == ST_BEAT0);
    assign beat1_en = (state_q == ST_BEAT1);
`else
    assign beat0_en = (state_q == ST_BEAT0) && aligned;
    assign beat1_en = 1'b0;
`endif

    // Banks at or above the offset hold row r (first beat); lower banks hold row r+1.
    for (genvar b = 0; b < LANES; b++) begin : g_bank
        assign bank_lane[b]  = LANE_W'(rot_idx(b, LANES - 32'(off), LANES));
        assign lane_bank[b]  = LANE_W'(rot_idx(b, 32'(off), LANES));
        assign wbyte[b]      = wdata_q[8*b +: 8];
        assign bank_first[b] = (LANE_W'(b) >= off);
`ifdef BLMEM_MISALIGN_EN
        assign bank_addr[b]  = bank_first[b] ? row_q : row_nxt;
`else
        assign bank_addr[b]  = row_q;
`endif
        assign bank_wdata[b] = wbyte[bank_lane[b]];
        assign bank_we[b]    = wr_q && be_q[bank_lane[b]] &&
                               ((beat0_en && bank_first[b]) || (beat1_en && !bank_first[b]));

        mem_byte_bank #(
            .DEPTH  (DEPTH),
            .ADDR_W (ROW_W)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .addr    (bank_addr[b]),
            .wdata   (bank_wdata[b]),
            .rdata_c (bank_rdata[b])
        );
    end

    // Next state and response payload.
    always_comb begin
        state_d = state_q;
        rdata_d = rsp_rdata_q;
        err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BEAT0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_BEAT0: begin
                if (aligned) begin
                    state_d = ST_RESP;
                end else begin
`ifdef BLMEM_MISALIGN_EN
                    state_d = ST_BEAT1;
`else
                    state_d = ST_RESP;
                    err_d   = 1'b1;
`endif
                end
            end
`ifdef BLMEM_MISALIGN_EN
            ST_BEAT1: state_d = ST_RESP;
`endif
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        for (int i = 0; i < LANES; i++) begin
            if (!wr_q && be_q[i] &&
                ((beat0_en && bank_first[lane_bank[i]]) || (beat1_en && !bank_first[lane_bank[i]])))
                rdata_d[8*i +: 8] = bank_rdata[lane_bank[i]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            if (accept) begin
                wr_q    <= bus.req_wr;
                addr_q  <= bus.req_addr;
                be_q    <= bus.req_be;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_byte_lane_memory_ctrl.sv
// Randomized bench for byte_lane_memory_ctrl against a flat byte-array model.
module tb_byte_lane_memory_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
`ifdef BLMEM_MISALIGN_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] mem_m   [65536];
    bit         known_m [65536];

    always #5 clk = ~clk;

    byte_lane_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    byte_lane_memory_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int unsigned waitc;
        waitc = 0;
        while (bus.req_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
    endtask

    // One request/response with model-derived expectations; hold = cycles of response backpressure.
    task automatic do_op(input logic wr, input logic [15:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int unsigned hold, output logic [31:0] rdata);
        logic        mis, exp_err;
        int unsigned exp_lat, lat;
        logic [31:0] exp_rd, mask;
        logic [15:0] b;
        mis     = (addr[1:0] != 2'b00);
        exp_err = mis && !SPLIT;
        exp_lat = (mis && SPLIT) ? 3 : 2;
        exp_rd  = '0;
        mask    = '1;
        rdata   = '0;
        if (!exp_err) begin
            for (int i = 0; i < 4; i++) begin
                b = addr + 16'(i);
                if (be[i]) begin
                    if (wr) begin
                        mem_m[b]   = wdata[8*i +: 8];
                        known_m[b] = 1'b1;
                    end else begin
                        exp_rd[8*i +: 8] = mem_m[b];
                        if (!known_m[b]) mask[8*i +: 8] = 8'h00;
                    end
                end
            end
        end
        wait_ready();
        chk("req_ready_wait", 64'(bus.req_ready), 64'(1));
        if (bus.req_ready !== 1'b1) return;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", 64'(lat), 64'(exp_lat));
        if (bus.rsp_valid !== 1'b1) return;
        chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        chk("rsp_rdata", 64'(bus.rsp_rdata & mask), 64'(exp_rd & mask));
        rdata = bus.rsp_rdata;
        for (int h = 0; h < int'(hold); h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
            chk("hold_rdata", 64'(bus.rsp_rdata & mask), 64'(exp_rd & mask));
            chk("hold_err", 64'(bus.rsp_err), 64'(exp_err));
            chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 64'(bus.rsp_valid), 64'(0));
        chk("ready_back", 64'(bus.req_ready), 64'(1));
    endtask

    // Issue a write and pull reset abort_at cycles after the accept edge.
    task automatic reset_abort(input logic [15:0] addr, input logic [31:0] wdata, input int unsigned abort_at);
        wait_ready();
        chk("abort_ready", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = addr;
        bus.req_be    = 4'hF;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k < int'(abort_at); k++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid_now", 64'(bus.rsp_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("abort_valid_edge", 64'(bus.rsp_valid), 64'(0));
        chk("abort_ready_low", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 64'(bus.req_ready), 64'(1));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [15:0] a;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_be    = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 64'(bus.req_ready), 64'(1));

        do_op(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 0, rd);
        do_op(1'b0, 16'h0010, 4'hF, 32'h0, 0, rd);
        chk("aligned_read", 64'(rd), 64'(32'hDEADBEEF));

        do_op(1'b1, 16'h0013, 4'hF, 32'h44332211, 0, rd);
        do_op(1'b0, 16'h0013, 4'hF, 32'h0, 0, rd);
`ifdef BLMEM_MISALIGN_EN
        chk("split_read", 64'(rd), 64'(32'h44332211));
        do_op(1'b0, 16'h0014, 4'hF, 32'h0, 0, rd);
        chk("split_tail", 64'(rd[23:0]), 64'(24'h443322));
`else
        chk("misaligned_rdata", 64'(rd), 64'(0));
`endif

        do_op(1'b1, 16'h0020, 4'hF, 32'h00000000, 0, rd);
        do_op(1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD, 0, rd);
        do_op(1'b0, 16'h0020, 4'hF, 32'h0, 0, rd);
        chk("partial_be", 64'(rd), 64'(32'h00BB00DD));
        do_op(1'b1, 16'h0020, 4'h0, 32'hFFFFFFFF, 0, rd);
        do_op(1'b0, 16'h0020, 4'hF, 32'h0, 0, rd);
        chk("zero_be_write", 64'(rd), 64'(32'h00BB00DD));

        do_op(1'b1, 16'hFFFE, 4'hF, 32'h04030201, 0, rd);
        do_op(1'b0, 16'h0000, 4'b0011, 32'h0, 0, rd);
`ifdef BLMEM_MISALIGN_EN
        chk("top_wrap", 64'(rd), 64'(32'h00000403));
`endif

        do_op(1'b0, 16'h0010, 4'hF, 32'h0, 5, rd);
        chk("backpressure_read", 64'(rd), 64'(32'hDEADBEEF));

        do_op(1'b1, 16'h0040, 4'hF, 32'h11111111, 0, rd);
        do_op(1'b1, 16'h0044, 4'hF, 32'h22222222, 0, rd);
`ifdef BLMEM_MISALIGN_EN
        reset_abort(16'h0042, 32'hA4A3A2A1, 2);
        mem_m[16'h0042] = 8'hA1;
        mem_m[16'h0043] = 8'hA2;
        do_op(1'b0, 16'h0040, 4'hF, 32'h0, 0, rd);
        chk("abort_beat0_kept", 64'(rd), 64'(32'hA2A11111));
        do_op(1'b0, 16'h0044, 4'hF, 32'h0, 0, rd);
        chk("abort_beat1_skip", 64'(rd), 64'(32'h22222222));
`else
        reset_abort(16'h0040, 32'hA4A3A2A1, 1);
        do_op(1'b0, 16'h0040, 4'hF, 32'h0, 0, rd);
        chk("abort_no_write", 64'(rd), 64'(32'h11111111));
        do_op(1'b0, 16'h0011, 4'hF, 32'h0, 0, rd);
        chk("misaligned_err_rdata", 64'(rd), 64'(0));
`endif

        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63))
                                            : 16'(16'hFFC0 + $urandom_range(0, 63));
            do_op(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 2), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
